turf_command_transmitter: RTL

TURF_COMMAND_TRANSMITTER -- requirements
Module: turf_command_transmitter

---
 rtl/turf_command_transmitter_if.sv | 20 ++
 rtl/turf_command_transmitter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/turf_command_transmitter_if.sv
// Command-transmitter bus: send request with latched payload, status and serial line back.
interface turf_command_transmitter_if;
  logic        send_i;
  logic [1:0]  lab_id_i;
  logic [31:0] event_id_i;
  logic        ready_o;
  logic        done_o;
  logic        cmd_o;
  logic [8:0]  debug_o;

  modport master (
    output send_i, lab_id_i, event_id_i,
    input  ready_o, done_o, cmd_o, debug_o
  );

  modport slave (
    input  send_i, lab_id_i, event_id_i,
    output ready_o, done_o, cmd_o, debug_o
  );
endinterface

// File: rtl/turf_command_transmitter.sv
// Serialises a 7-byte 8N1 command frame; start bit one cycle after accept, 7*10*OVERSAMPLE clocks per frame.
// No queue: send_i is only taken while ready_o=1 (idle or the done_o cycle), ignored otherwise.
module turf_command_transmitter #(
  parameter logic [7:0] TX_HEADER  = 8'hA6,
  parameter int         OVERSAMPLE = 16
) (
  input  logic                        clk33_i,
  input  logic                        rst_i,
  turf_command_transmitter_if.slave   bus
);

  localparam int             BW        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(OVERSAMPLE - 1);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t        r_state;
  logic [2:0]    r_byte;
  logic [3:0]    r_bit;
  logic [BW-1:0] r_baud;
  logic [1:0]    r_lab;
  logic [31:0]   r_event;
  logic [7:0]    r_chk;
  logic          r_cmd;
  logic          r_ready;
  logic          r_done;
  logic [8:0]    r_debug;

  logic          w_baud_wrap;
  logic          w_bit_wrap;
  logic          w_last;
  logic [BW-1:0] w_nxt_baud;
  logic [3:0]    w_nxt_bit;
  logic [2:0]    w_nxt_byte;
  logic [7:0]    w_nxt_dat;
  logic          w_nxt_line;
  logic [7:0]    w_ev_sum;

  assign w_baud_wrap = (r_baud == BAUD_LAST);
  assign w_bit_wrap  = w_baud_wrap && (r_bit == 4'd9);
  assign w_last      = w_bit_wrap && (r_byte == 3'd6);

  assign w_nxt_baud = w_baud_wrap ? '0 : r_baud + BW'(1);
  assign w_nxt_bit  = w_baud_wrap ? ((r_bit == 4'd9) ? 4'd0 : r_bit + 4'd1) : r_bit;
  assign w_nxt_byte = w_bit_wrap ? r_byte + 3'd1 : r_byte;

  // Carries out of bit 7 are intentionally dropped.
  assign w_ev_sum = event_id_i_b(3) + event_id_i_b(2) + event_id_i_b(1) + event_id_i_b(0);

  function automatic logic [7:0] event_id_i_b(input int idx);
    return bus.event_id_i[idx*8 +: 8];
  endfunction

  // Output line and debug byte are looked up for the position the counters move to,
  // so the registered cmd_o lines up with the counters on the same cycle.
  always_comb begin
    w_nxt_dat = TX_HEADER;
    case (w_nxt_byte)
      3'd0:    w_nxt_dat = TX_HEADER;
      3'd1:    w_nxt_dat = {6'b0, r_lab};
      3'd2:    w_nxt_dat = r_event[31:24];
      3'd3:    w_nxt_dat = r_event[23:16];
      3'd4:    w_nxt_dat = r_event[15:8];
      3'd5:    w_nxt_dat = r_event[7:0];
      default: w_nxt_dat = r_chk;
    endcase
  end

  always_comb begin
    w_nxt_line = 1'b1;
    case (w_nxt_bit)
      4'd0:    w_nxt_line = 1'b0;
      4'd9:    w_nxt_line = 1'b1;
      default: w_nxt_line = w_nxt_dat[3'(w_nxt_bit[2:0] - 3'd1)];
    endcase
  end

  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_byte  <= '0;
      r_bit   <= '0;
      r_baud  <= '0;
      r_lab   <= '0;
      r_event <= '0;
      r_chk   <= '0;
      r_cmd   <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_debug <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.send_i) begin
            r_state <= ST_SEND;
            r_byte  <= '0;
            r_bit   <= '0;
            r_baud  <= '0;
            r_lab   <= bus.lab_id_i;
            r_event <= bus.event_id_i;
            r_chk   <= w_ev_sum;
            r_cmd   <= 1'b0;
            r_ready <= 1'b0;
            r_debug <= {1'b1, TX_HEADER};
          end
        end
        ST_SEND: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            r_byte  <= '0;
            r_bit   <= '0;
            r_baud  <= '0;
            r_cmd   <= 1'b1;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_debug <= '0;
          end else begin
            r_byte  <= w_nxt_byte;
            r_bit   <= w_nxt_bit;
            r_baud  <= w_nxt_baud;
            r_cmd   <= w_nxt_line;
            r_debug <= {1'b1, w_nxt_dat};
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready_o = r_ready;
  assign bus.done_o  = r_done;
  assign bus.cmd_o   = r_cmd;
  assign bus.debug_o = r_debug;

endmodule
